truco_hand_sequencer: RTL and testbench

Producer side of the per-hand round-result vectors consumed by the score memory block. It accepts one judged round result per strobe and tracks up to three rounds of a Truco hand. It resolves the hand winner under best-of-three and tie rules, applies the current hand value (1/3/6/9/12 after truco raises) to saturating match scores, and drives the P1/P2 round-win vectors plus a one-cycle hand-complete strobe.

---
 rtl/truco_hand_sequencer_pkg.sv | 74 +++++++
 rtl/truco_hand_sequencer_if.sv | 27 ++
 rtl/truco_hand_sequencer_value_ctr.sv | 19 +
 rtl/truco_hand_sequencer.sv | 112 +++++++++++
 tb/tb_truco_hand_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/truco_hand_sequencer_pkg.sv
// Shared encodings, hand-value step table and hand-resolution helper for the
// Truco hand sequencer.
package truco_pkg;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_P1   = 2'b01,
      RES_P2   = 2'b10,
      RES_TIE  = 2'b11
   } result_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10
   } winner_t;

   typedef enum logic [1:0] {
      PLAY   = 2'd0,
      SETTLE = 2'd1,
      OVER   = 2'd2
   } state_t;

   typedef struct packed {
      logic    done;
      winner_t winner;
   } resolve_t;

   localparam logic [3:0] HAND_STEPS [5] = '{4'd1, 4'd3, 4'd6, 4'd9, 4'd12};

   // Next rung of the raise ladder; the top rung maps onto itself.
   function automatic logic [3:0] next_value(input logic [3:0] v);
      logic [3:0] n;
      n = HAND_STEPS[4];
      for (int i = 0; i < 4; i++)
         if (v == HAND_STEPS[i]) n = HAND_STEPS[i+1];
      return n;
   endfunction

   // p1/p2 hold won-or-tied bits per round; n is the number of rounds played.
   function automatic resolve_t resolve(input logic [2:0] p1, input logic [2:0] p2,
                                        input logic [1:0] n);
      resolve_t   r;
      logic [2:0] d1, d2, t;
      int         w1, w2;
      d1 = p1 & ~p2;
      d2 = p2 & ~p1;
      t  = p1 & p2;
      w1 = $countones(d1);
      w2 = $countones(d2);
      r.done   = 1'b0;
      r.winner = WIN_NONE;
      if (w1 == 2) begin
         r.done = 1'b1; r.winner = WIN_P1;
      end else if (w2 == 2) begin
         r.done = 1'b1; r.winner = WIN_P2;
      end else if (n >= 2'd2) begin
         if (t[0] && !t[1]) begin
            r.done = 1'b1; r.winner = d1[1] ? WIN_P1 : WIN_P2;
         end else if (!t[0] && t[1]) begin
            r.done = 1'b1; r.winner = d1[0] ? WIN_P1 : WIN_P2;
         end else if (n == 2'd3) begin
            // A split that reaches here had a tied third round: round 1 decides.
            r.done = 1'b1;
            if (t[0])
               r.winner = d1[2] ? WIN_P1 : (d2[2] ? WIN_P2 : WIN_NONE);
            else
               r.winner = d1[0] ? WIN_P1 : WIN_P2;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/truco_hand_sequencer_if.sv
// Round-input / hand-result bundle between the round judge and the score memory.
interface truco_hand_sequencer_if #(parameter int SCORE_W = 4) ();
   logic               round_valid;
   logic [1:0]         round_result;
   logic               truco_req;
   logic [2:0]         P1;
   logic [2:0]         P2;
   logic [1:0]         round_idx;
   logic [3:0]         hand_value;
   logic               hand_done;
   logic [1:0]         hand_winner;
   logic [SCORE_W-1:0] score1;
   logic [SCORE_W-1:0] score2;
   logic               game_over;

   modport master (
      output round_valid, round_result, truco_req,
      input  P1, P2, round_idx, hand_value, hand_done, hand_winner,
             score1, score2, game_over
   );

   modport slave (
      input  round_valid, round_result, truco_req,
      output P1, P2, round_idx, hand_value, hand_done, hand_winner,
             score1, score2, game_over
   );
endinterface

// File: rtl/truco_hand_sequencer_value_ctr.sv
// Registered hand-value raise counter walking the 1/3/6/9/12 ladder.
module truco_value_ctr
   import truco_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       step,
   input  logic       load_one,
   output logic [3:0] value
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (clr || load_one) value <= HAND_STEPS[0];
      else if (step)       value <= next_value(value);
   end

endmodule

// File: rtl/truco_hand_sequencer.sv
// Tracks the rounds of one Truco hand, resolves the winner and accumulates
// saturating match scores.
module truco_hand_sequencer
   import truco_pkg::*;
#(
   parameter int TARGET  = 12,
   parameter int SCORE_W = 4
) (
   input logic                    clk,
   input logic                    clr,
   truco_hand_sequencer_if.slave  bus
);

   localparam logic [SCORE_W-1:0] TARGET_S = SCORE_W'(TARGET);

   state_t             state, state_nxt;
   logic [2:0]         p1_q, p2_q, p1_set, p2_set;
   logic [1:0]         idx_q;
   winner_t            winner_q;
   logic [SCORE_W-1:0] s1_q, s2_q;
   logic [3:0]         value, eff_value;
   logic               accept, raise, settle, hand_done, game_over;
   resolve_t           res;

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                  input logic [3:0] v);
      int sum;
      sum = int'(s) + int'(v);
      if (sum > TARGET) sum = TARGET;
      return SCORE_W'(sum);
   endfunction

   assign accept    = (state == PLAY) && bus.round_valid && (bus.round_result != RES_NONE);
   assign raise     = (state == PLAY) && bus.truco_req;
   // A raise in the same cycle as the deciding round scores at the raised value.
   assign eff_value = raise ? next_value(value) : value;
   assign p1_set    = p1_q | (3'(bus.round_result[0]) << idx_q);
   assign p2_set    = p2_q | (3'(bus.round_result[1]) << idx_q);
   assign res       = resolve(p1_set, p2_set, idx_q + 2'd1);

   truco_value_ctr u_value_ctr (
      .clk      (clk),
      .clr      (clr),
      .step     (raise),
      .load_one (settle),
      .value    (value)
   );

   always_ff @(posedge clk) begin
      if (clr) state <= PLAY;
      else     state <= state_nxt;
   end

   // NOTE: combinational outputs get a default before any branch so no
   // path leaves them unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         PLAY:    if (accept && res.done) state_nxt = SETTLE;
         SETTLE:  state_nxt = (s1_q == TARGET_S || s2_q == TARGET_S) ? OVER : PLAY;
         OVER:    state_nxt = OVER;
         default: state_nxt = PLAY;
      endcase
   end

   always_comb begin
      hand_done = 1'b0;
      game_over = 1'b0;
      settle    = 1'b0;
      case (state)
         SETTLE:  begin hand_done = 1'b1; settle = 1'b1; end
         OVER:    game_over = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         p1_q     <= '0;
         p2_q     <= '0;
         idx_q    <= '0;
         winner_q <= WIN_NONE;
         s1_q     <= '0;
         s2_q     <= '0;
      end else if (accept) begin
         p1_q  <= p1_set;
         p2_q  <= p2_set;
         idx_q <= (idx_q == 2'd2) ? 2'd2 : idx_q + 2'd1;
         if (res.done) begin
            winner_q <= res.winner;
            if (res.winner == WIN_P1) s1_q <= sat_add(s1_q, eff_value);
            if (res.winner == WIN_P2) s2_q <= sat_add(s2_q, eff_value);
         end
      end else if (settle) begin
         p1_q     <= '0;
         p2_q     <= '0;
         idx_q    <= '0;
         winner_q <= WIN_NONE;
      end
   end

   assign bus.P1          = p1_q;
   assign bus.P2          = p2_q;
   assign bus.round_idx   = idx_q;
   assign bus.hand_value  = value;
   assign bus.hand_done   = hand_done;
   assign bus.hand_winner = winner_q;
   assign bus.score1      = s1_q;
   assign bus.score2      = s2_q;
   assign bus.game_over   = game_over;

endmodule

// File: tb/tb_truco_hand_sequencer.sv
// Directed bench for truco_hand_sequencer: a per-cycle vector table followed by
// hand-written sequences for round-3 resolution and score saturation.
module tb_truco_hand_sequencer;

   logic clk = 1'b0;
   logic clr;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   truco_hand_sequencer_if #(.SCORE_W(4)) bus ();

   truco_hand_sequencer #(.TARGET(12), .SCORE_W(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   typedef struct {
      logic       c;
      logic       rv;
      logic [1:0] rr;
      logic       tr;
      logic [2:0] p1;
      logic [2:0] p2;
      logic [1:0] idx;
      logic [3:0] val;
      logic       done;
      logic [1:0] win;
      logic [3:0] s1;
      logic [3:0] s2;
      logic       go;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int c, int rv, int rr, int tr, int p1, int p2, int idx,
                               int val, int done, int win, int s1, int s2, int go);
      vec_t v;
      v.c = 1'(c);     v.rv = 1'(rv);   v.rr = 2'(rr);     v.tr = 1'(tr);
      v.p1 = 3'(p1);   v.p2 = 3'(p2);   v.idx = 2'(idx);   v.val = 4'(val);
      v.done = 1'(done); v.win = 2'(win); v.s1 = 4'(s1);   v.s2 = 4'(s2);
      v.go = 1'(go);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input logic c, input logic rv, input logic [1:0] rr, input logic tr);
      clr              = c;
      bus.round_valid  = rv;
      bus.round_result = rr;
      bus.truco_req    = tr;
      @(posedge clk);
      #1;
      clr              = 1'b0;
      bus.round_valid  = 1'b0;
      bus.round_result = 2'b00;
      bus.truco_req    = 1'b0;
   endtask

   task automatic check_all(input string tag, input vec_t e);
      check({tag, ".P1"},          32'(bus.P1),          32'(e.p1));
      check({tag, ".P2"},          32'(bus.P2),          32'(e.p2));
      check({tag, ".round_idx"},   32'(bus.round_idx),   32'(e.idx));
      check({tag, ".hand_value"},  32'(bus.hand_value),  32'(e.val));
      check({tag, ".hand_done"},   32'(bus.hand_done),   32'(e.done));
      check({tag, ".hand_winner"}, 32'(bus.hand_winner), 32'(e.win));
      check({tag, ".score1"},      32'(bus.score1),      32'(e.s1));
      check({tag, ".score2"},      32'(bus.score2),      32'(e.s2));
      check({tag, ".game_over"},   32'(bus.game_over),   32'(e.go));
   endtask

   initial begin
      //                 c rv rr tr | P1 P2 idx val done win s1 s2 go
      vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,  1,  0,  0,  0, 0, 0)); // reset
      vecs.push_back(mk(0, 1, 1, 0,   1, 0, 1,  1,  0,  0,  0, 0, 0)); // P1
      vecs.push_back(mk(0, 1, 1, 0,   3, 0, 2,  1,  1,  1,  1, 0, 0)); // P1 -> P1 wins
      vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,  1,  0,  0,  1, 0, 0));
      vecs.push_back(mk(0, 1, 3, 0,   1, 1, 1,  1,  0,  0,  1, 0, 0)); // tie
      vecs.push_back(mk(0, 1, 2, 0,   1, 3, 2,  1,  1,  2,  1, 1, 0)); // P2 -> P2 wins
      vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,  1,  0,  0,  1, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0,   1, 0, 1,  1,  0,  0,  1, 1, 0)); // P1
      vecs.push_back(mk(0, 1, 2, 0,   1, 2, 2,  1,  0,  0,  1, 1, 0)); // P2 split
      vecs.push_back(mk(0, 1, 3, 0,   5, 6, 2,  1,  1,  1,  2, 1, 0)); // tie -> round-1 winner
      vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,  1,  0,  0,  2, 1, 0));
      vecs.push_back(mk(0, 1, 3, 0,   1, 1, 1,  1,  0,  0,  2, 1, 0)); // tie
      vecs.push_back(mk(0, 1, 3, 0,   3, 3, 2,  1,  0,  0,  2, 1, 0)); // tie
      vecs.push_back(mk(0, 1, 3, 0,   7, 7, 2,  1,  1,  0,  2, 1, 0)); // tie -> nobody
      vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,  1,  0,  0,  2, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0,  1,  0,  0,  2, 1, 0)); // illegal 00
      vecs.push_back(mk(0, 0, 0, 1,   0, 0, 0,  3,  0,  0,  2, 1, 0)); // truco
      vecs.push_back(mk(0, 0, 0, 1,   0, 0, 0,  6,  0,  0,  2, 1, 0)); // truco
      vecs.push_back(mk(0, 1, 2, 0,   0, 1, 1,  6,  0,  0,  2, 1, 0)); // P2
      vecs.push_back(mk(0, 1, 2, 0,   0, 3, 2,  6,  1,  2,  2, 7, 0)); // P2 wins 6
      vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,  1,  0,  0,  2, 7, 0));
      vecs.push_back(mk(0, 1, 1, 0,   1, 0, 1,  1,  0,  0,  2, 7, 0)); // P1
      vecs.push_back(mk(0, 1, 1, 1,   3, 0, 2,  3,  1,  1,  5, 7, 0)); // P1 + raise: scores 3
      vecs.push_back(mk(0, 1, 2, 1,   0, 0, 0,  1,  0,  0,  5, 7, 0)); // ignored in SETTLE
      vecs.push_back(mk(0, 0, 0, 1,   0, 0, 0,  3,  0,  0,  5, 7, 0));
      vecs.push_back(mk(0, 0, 0, 1,   0, 0, 0,  6,  0,  0,  5, 7, 0));
      vecs.push_back(mk(0, 0, 0, 1,   0, 0, 0,  9,  0,  0,  5, 7, 0));
      vecs.push_back(mk(0, 0, 0, 1,   0, 0, 0, 12,  0,  0,  5, 7, 0));
      vecs.push_back(mk(0, 0, 0, 1,   0, 0, 0, 12,  0,  0,  5, 7, 0)); // capped at 12
      vecs.push_back(mk(0, 1, 2, 0,   0, 1, 1, 12,  0,  0,  5, 7, 0)); // P2
      vecs.push_back(mk(0, 1, 2, 0,   0, 3, 2, 12,  1,  2,  5,12, 0)); // 7+12 saturates
      vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,  1,  0,  0,  5,12, 1)); // OVER
      vecs.push_back(mk(0, 1, 1, 1,   0, 0, 0,  1,  0,  0,  5,12, 1)); // ignored in OVER
      vecs.push_back(mk(1, 1, 1, 1,   0, 0, 0,  1,  0,  0,  0, 0, 0)); // clr dominates

      clr = 1'b0;
      bus.round_valid  = 1'b0;
      bus.round_result = 2'b00;
      bus.truco_req    = 1'b0;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].c, vecs[i].rv, vecs[i].rr, vecs[i].tr);
         check_all($sformatf("v%0d", i), vecs[i]);
      end

      // P2 then tie: round-1 winner takes the hand.
      cyc(0, 1, 2'b10, 0);
      cyc(0, 1, 2'b11, 0);
      check("p2tie.P1", 32'(bus.P1), 32'd2);
      check("p2tie.P2", 32'(bus.P2), 32'd3);
      check("p2tie.winner", 32'(bus.hand_winner), 32'd2);
      check("p2tie.score2", 32'(bus.score2), 32'd1);
      cyc(0, 0, 2'b00, 0);

      // Split then decisive round 3.
      cyc(0, 1, 2'b01, 0);
      cyc(0, 1, 2'b10, 0);
      check("split.nodone", 32'(bus.hand_done), 32'd0);
      cyc(0, 1, 2'b10, 0);
      check("split.P1", 32'(bus.P1), 32'd1);
      check("split.P2", 32'(bus.P2), 32'd6);
      check("split.winner", 32'(bus.hand_winner), 32'd2);
      check("split.score2", 32'(bus.score2), 32'd2);
      cyc(0, 0, 2'b00, 0);

      // Climb score1 to 11: one hand at 9, two at 1.
      for (int k = 0; k < 3; k++) begin
         if (k == 0) repeat (3) cyc(0, 0, 2'b00, 1);
         cyc(0, 1, 2'b01, 0);
         cyc(0, 1, 2'b01, 0);
         check($sformatf("climb%0d.score1", k), 32'(bus.score1), (k == 0) ? 32'd9 : 32'(9 + k));
         cyc(0, 0, 2'b00, 0);
      end

      cyc(0, 0, 2'b00, 1);
      cyc(0, 1, 2'b01, 0);
      cyc(0, 1, 2'b01, 0);
      check("sat.score1", 32'(bus.score1), 32'd12);
      check("sat.done", 32'(bus.hand_done), 32'd1);
      check("sat.game_over_pending", 32'(bus.game_over), 32'd0);
      cyc(0, 0, 2'b00, 0);
      check("over.game_over", 32'(bus.game_over), 32'd1);
      check("over.P1", 32'(bus.P1), 32'd0);
      cyc(0, 1, 2'b01, 1);
      cyc(0, 1, 2'b01, 1);
      check("over.hold_P1", 32'(bus.P1), 32'd0);
      check("over.hold_value", 32'(bus.hand_value), 32'd1);
      check("over.hold_score1", 32'(bus.score1), 32'd12);
      check("over.hold_score2", 32'(bus.score2), 32'd2);
      check("over.hold_go", 32'(bus.game_over), 32'd1);
      cyc(1, 0, 2'b00, 0);
      check("clr.score1", 32'(bus.score1), 32'd0);
      check("clr.score2", 32'(bus.score2), 32'd0);
      check("clr.value", 32'(bus.hand_value), 32'd1);
      check("clr.game_over", 32'(bus.game_over), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
